muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/rv32i_types.sv | 39 +++
 rtl/md_sign_fix.sv | 14 +
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I encodings: ALU ops, M-extension multiply/divide ops, muldiv FSM states.
package rv32i_types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Matches funct3 of the RV32M instructions.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;
  localparam int unsigned MD_CNT_W = $clog2(MD_ITERS);
  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_ITERS - 1);

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign.
module md_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  always_comb begin
    res = neg ? (~val + W'(1)) : val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, 32 cycles.
module muldiv_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  md_op,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f
);

  md_state_t           state_q;
  md_op_t              op_q;
  logic                neg_q;
  logic [31:0]         opnd_q;
  logic [63:0]         acc_q;
  logic [MD_CNT_W-1:0] cnt_q;

  md_op_t      op_in;
  logic        sa, sb, neg_in, is_div, div_zero, ovf;
  logic [31:0] abs_a, abs_b, special_res;

  always_comb begin
    op_in    = md_op_t'(md_op);
    is_div   = md_op[2];
    sa       = a[31] && (op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb       = b[31] && (op_in inside {MD_MULH, MD_DIV, MD_REM});
    neg_in   = (op_in == MD_REM) ? sa : (sa ^ sb);
    div_zero = is_div && (b == '0);
    ovf      = (op_in inside {MD_DIV, MD_REM}) && (a == 32'h8000_0000) && (b == '1);
    if (div_zero) special_res = md_op[1] ? a : '1;
    else          special_res = md_op[1] ? '0 : 32'h8000_0000;
  end

  md_sign_fix #(.W(32)) u_fix_a (.val(a), .neg(sa), .res(abs_a));
  md_sign_fix #(.W(32)) u_fix_b (.val(b), .neg(sb), .res(abs_b));

  // acc holds {partial product, multiplier} for multiply, {remainder, quotient} for divide.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] acc_nxt, fix_in, fix_out;
  logic [31:0] result;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2])
      acc_nxt = div_diff[32] ? {acc_q[62:0], 1'b0} : {div_diff[31:0], acc_q[30:0], 1'b1};
    else
      acc_nxt = {mul_sum, acc_q[31:1]};
    if (op_q[2]) fix_in = {32'h0, op_q[1] ? acc_nxt[63:32] : acc_nxt[31:0]};
    else         fix_in = acc_nxt;
  end

  // The full 64-bit product is negated so the high word carries correctly.
  md_sign_fix #(.W(64)) u_fix_f (.val(fix_in), .neg(neg_q), .res(fix_out));

  always_comb begin
    result = (op_q == MD_MUL || op_q[2]) ? fix_out[31:0] : fix_out[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      f         <= '0;
    end else if (flush) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      f         <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            op_q     <= op_in;
            neg_q    <= neg_in;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            if (div_zero || ovf) begin
              state_q   <= MD_DONE;
              out_valid <= 1'b1;
              f         <= special_res;
            end else begin
              state_q <= MD_BUSY;
              acc_q   <= {32'h0, is_div ? abs_a : abs_b};
              opnd_q  <= is_div ? abs_b : abs_a;
            end
          end
        end
        MD_BUSY: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == MD_LAST) begin
            state_q   <= MD_DONE;
            out_valid <= 1'b1;
            f         <= result;
            cnt_q     <= '0;
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            state_q   <= MD_IDLE;
            out_valid <= 1'b0;
            f         <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= MD_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          f         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  md_op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .md_op(md_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .f(f)
  );

  // Issues one op, returns the result and the number of negedges from accept to out_valid.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    md_op = op; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = f;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; md_op = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== 32'h0) begin
      errors++;
      $display("FAIL reset_held in_ready=%b out_valid=%b f=%h required 1 0 00000000", in_ready, out_valid, f);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== 32'h0) begin
      errors++;
      $display("FAIL reset_released in_ready=%b out_valid=%b f=%h required 1 0 00000000", in_ready, out_valid, f);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  ops [6] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_MULHU, MD_MULH};
    logic [31:0] xs  [6] = '{32'h7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ys  [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [6] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0};
    logic [31:0] r;
    int l;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], xs[i], ys[i], r, l);
      checks++;
      if (r !== exp[i]) begin
        errors++;
        $display("FAIL mul_%0d f=%h required %h", i, r, exp[i]);
      end
      checks++;
      if (l !== 33) begin
        errors++;
        $display("FAIL mul_latency_%0d got %0d required 33", i, l);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [6] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU, MD_DIV, MD_REM};
    logic [31:0] xs  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] ys  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    logic [31:0] r;
    int l;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], xs[i], ys[i], r, l);
      checks++;
      if (r !== exp[i] || l !== 33) begin
        errors++;
        $display("FAIL div_%0d f=%h lat=%0d required %h lat=33", i, r, l, exp[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  ops [6] = '{MD_DIVU, MD_REMU, MD_DIV, MD_REM, MD_DIV, MD_REM};
    logic [31:0] xs  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] ys  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] r;
    int l;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], xs[i], ys[i], r, l);
      checks++;
      if (r !== exp[i] || l !== 1) begin
        errors++;
        $display("FAIL special_%0d f=%h lat=%0d required %h lat=1", i, r, l, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] hold;
    logic bad;
    int l;
    @(negedge clk);
    md_op = MD_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    l = 1;
    while (!out_valid && l < 100) begin
      @(negedge clk);
      l++;
    end
    hold = f;
    checks++;
    if (hold !== 32'hFFFF_FFFE || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_result f=%h out_valid=%b required fffffffe 1", hold, out_valid);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (f !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_stall f=%h in_ready=%b out_valid=%b required %h 0 1", f, in_ready, out_valid, hold);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== 32'h0) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b f=%h required 1 0 00000000", in_ready, out_valid, f);
    end
  endtask

  task automatic test_flush;
    logic seen;
    // Flush during BUSY.
    @(negedge clk);
    md_op = MD_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_busy_no_result out_valid seen=1 required 0");
    end
    // Flush in IDLE blocks the offered op.
    md_op = MD_DIVU; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    // Flush in DONE wins over a held result.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || f !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL flush_done_pre out_valid=%b f=%h required 1 ffffffff", out_valid, f);
    end
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== 32'h0) begin
      errors++;
      $display("FAIL flush_done in_ready=%b out_valid=%b f=%h required 1 0 00000000", in_ready, out_valid, f);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    logic [31:0] r;
    int l;
    @(negedge clk);
    md_op = MD_MUL; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid in_ready=%b out_valid=%b f=%h required 1 0 00000000", in_ready, out_valid, f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_result out_valid seen=1 required 0");
    end
    run_op(MD_DIVU, 32'd100, 32'd7, r, l);
    checks++;
    if (r !== 32'd14 || l !== 33) begin
      errors++;
      $display("FAIL reset_mid_recover f=%h lat=%0d required 0000000e lat=33", r, l);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
